bpred_ctrl: RTL
===============

# bpred_ctrl

Branch prediction and redirect controller for the RV32 fetch/execute loop. It holds a direct-mapped table of 2-bit saturating counters and supplies the "predicted taken" flag and predicted target for each fetched conditional branch. It trains the table from branch resolutions reported by the jump-control stage, and sequences a fixed-length pipeline flush whenever that stage rewrites the PC. It also keeps wrap-around branch and mispredict counters for debug.

## Interface
Parameters:
- IDX_BITS, 4, table index width; the table holds 2^IDX_BITS counters.
- FLUSH_CYCLES, 2, number of cycles `flush` stays high per redirect; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nreset  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; when low, all state holds.
- fetch_pc  in  32  PC of the instruction in fetch.
- fetch_is_branch  in  1  fetched instruction is a conditional branch.
- fetch_imm  in  32  B-type immediate of the fetched branch.
- predict_taken  out  1  prediction flag, travels down the pipe to jump control.
- predict_target  out  32  fetch_pc + fetch_imm, bit 0 forced to 0.
- resolve_valid  in  1  a conditional branch resolved this cycle.
- resolve_pc  in  32  PC of the resolved branch.
- resolve_taken  in  1  actual branch outcome.
- redirect  in  1  jump control writes the PC this cycle (mispredict or jalr).
- flush  out  1  squash younger instructions in fetch/decode.
- branch_cnt  out  16  number of resolved branches, wraps.
- miss_cnt  out  16  number of redirects caused by branches, wraps.

## Operation
- The table has 2^IDX_BITS entries of 2 bits. The index is pc[IDX_BITS+1:2] for both fetch and resolve.
- Reset value of every entry is 2'b01 (weakly not-taken).
- Prediction is combinational:
  - predict_taken = fetch_is_branch & table[idx][1] & ~flush.
  - predict_target = (fetch_pc + fetch_imm) & 32'hFFFFFFFE, 32-bit wrap-around add.
- Training happens when resolve_valid & ena:
  - taken: the entry increments and saturates at 2'b11.
  - not taken: the entry decrements and saturates at 2'b00.
- Same-index read and write in one cycle: the prediction uses the old value. There is no bypass.
- Counters, updated only when ena is high:
  - branch_cnt += 1 when resolve_valid.
  - miss_cnt += 1 when resolve_valid & redirect.
  - A jalr redirect without resolve_valid does not count.
  - Both wrap from 16'hFFFF to 0.
- Flush FSM, with a 4-bit down-counter `cnt`:
  - IDLE: flush = 0. On redirect & ena, go to FLUSH with cnt = FLUSH_CYCLES-1.
  - FLUSH: flush = 1.
    - redirect & ena: stay in FLUSH and reload cnt = FLUSH_CYCLES-1 (restart).
    - otherwise, cnt == 0: go to IDLE.
    - otherwise: cnt decrements.
- When ena is low, the table, counters, FSM state and cnt all hold, and flush keeps its current value.
- When nreset is asserted at any time, including mid-flush:
  - All table entries go to 2'b01, the counters to 0 and the FSM to IDLE.
  - flush, predict_taken, branch_cnt and miss_cnt read 0 immediately (asynchronously).
  - predict_target stays combinational.

## Timing
- Prediction latency is 0 cycles: it is combinational from fetch_pc, fetch_is_branch and fetch_imm.
- A table update is visible to a fetch in the cycle after the resolve edge.
- flush rises in the cycle after the redirect edge and stays high for exactly FLUSH_CYCLES cycles, unless it is restarted.
- The counters reflect an event in the cycle after the event.
- Resolve and redirect are single-cycle pulses; there is no handshake or back-pressure.

## Test plan
- Reset behaviour: pulse nreset low mid-cycle; flush, predict_taken and both counters go 0 before the next edge. Then fetch_pc=0x40 with fetch_is_branch=1 -> predict_taken=0 (entry is 01).
- Training saturation: resolve_pc=0x100, resolve_taken=1, three pulses -> entry goes 01→10→11→11.
  - Fetch at 0x100 -> predict_taken=1.
  - Fetch at 0x140 (same index for IDX_BITS=4) -> predict_taken=1 (alias).
  - Two not-taken resolves at 0x100 -> entry 01, predict_taken=0.
- Target computation: fetch_pc=0xFFFFFFF0, fetch_imm=0x20 -> predict_target=0x00000010. fetch_imm=0xFFFFFFF8 -> 0xFFFFFFE8.
- Flush sequencing, FLUSH_CYCLES=2:
  - A redirect at cycle 5 -> flush high at cycles 6–7, low at cycle 8.
  - A second redirect at cycle 6 -> flush high through cycle 8.
  - predict_taken is forced to 0 while flush is high.
- Enable hold: ena=0 during FLUSH with resolve_valid=1 and redirect=1 -> table, cnt, counters and flush are all unchanged for those cycles. The sequence resumes when ena returns to 1.
- Counter wrap: preload by issuing 65536 resolve pulses, with redirect on every other one -> branch_cnt=0 and miss_cnt=32768. One jalr redirect with resolve_valid=0 leaves both unchanged.

Source files
------------

// File: rtl/bpred_ctrl.sv
// Branch predictor and redirect controller: a 2-bit saturating counter table for
// fetch-time prediction, a fixed-length flush sequencer and debug event counters.
module bpred_ctrl #(
  parameter int IDX_BITS     = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        ena,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_is_branch,
  input  logic [31:0] fetch_imm,
  output logic        predict_taken,
  output logic [31:0] predict_target,
  input  logic        resolve_valid,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic        redirect,
  output logic        flush,
  output logic [15:0] branch_cnt,
  output logic [15:0] miss_cnt
);

  localparam int          ENTRIES = 1 << IDX_BITS;
  localparam logic [3:0]  RELOAD  = 4'(FLUSH_CYCLES - 1);

  typedef enum logic {IDLE, FLUSH} state_t;

  logic [1:0]          pht_q [ENTRIES];
  logic [1:0]          entry_d;
  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] resolve_idx;
  logic [31:0]         target_sum;
  logic [15:0]         branch_cnt_q, branch_cnt_d;
  logic [15:0]         miss_cnt_q, miss_cnt_d;
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_BITS+1:2];
  assign resolve_idx    = resolve_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{resolve_pc[31:IDX_BITS+2], resolve_pc[1:0]};

  // The read sees the pre-edge table contents; a same-cycle resolve is not bypassed.
  assign predict_taken  = fetch_is_branch & pht_q[fetch_idx][1] & ~flush;
  assign target_sum     = fetch_pc + fetch_imm;
  assign predict_target = {target_sum[31:1], 1'b0};

  always_comb begin
    entry_d = pht_q[resolve_idx];
    if (resolve_taken) begin
      if (entry_d != 2'b11) entry_d = entry_d + 2'b01;
    end else begin
      if (entry_d != 2'b00) entry_d = entry_d - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= 2'b01;
    end else if (ena && resolve_valid) begin
      pht_q[resolve_idx] <= entry_d;
    end
  end

  // Only redirects that coincide with a branch resolution count as mispredicts.
  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (ena && resolve_valid) begin
      branch_cnt_d = branch_cnt_q + 16'd1;
      if (redirect) miss_cnt_d = miss_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A redirect during a flush restarts the full flush window.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (redirect) begin
            state_d = FLUSH;
            cnt_d   = RELOAD;
          end
        end
        FLUSH: begin
          if (redirect) begin
            cnt_d = RELOAD;
          end else if (cnt_q == 4'd0) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    flush = (state_q == FLUSH);
  end

endmodule
